// File: rtl/cavlc_level_encoder.sv
// CAVLC level codeword generator: walks a snapshot of the level list and
// emits prefix/suffix codewords with adaptive suffixLength to a packer.
module cavlc_level_encoder #(
  parameter int MAX_LEVELS = 16,
  parameter int COEFF_W    = 8,
  parameter int CODE_W     = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      h264_reset,
  input  logic                      start_i,
  input  logic signed [COEFF_W-1:0] level_list_i [MAX_LEVELS],
  input  logic [4:0]                level_cnt_i,
  input  logic [1:0]                t1s_i,
  input  logic [4:0]                total_i,
  input  logic                      code_ready_i,
  output logic                      code_valid_o,
  output logic [CODE_W-1:0]         code_bits_o,
  output logic [4:0]                code_len_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    EMIT,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic signed [COEFF_W-1:0] list [MAX_LEVELS];
  logic [4:0] cnt;
  logic [4:0] idx;
  logic [1:0] t1s;
  logic [2:0] sl;

  logic [4:0] cnt_in;
  logic [2:0] sl_init;
  logic       last;

  logic signed [COEFF_W-1:0] lv;
  logic signed [10:0] lvx;
  logic signed [10:0] neg;
  logic signed [10:0] lcs;
  logic [8:0]  lc;
  logic [8:0]  mag;
  logic [9:0]  thr;
  logic [9:0]  diff;
  logic [8:0]  shr;
  logic [3:0]  pre;
  logic [3:0]  slen;
  logic [11:0] suf;
  logic [CODE_W-1:0] bits;
  logic [4:0]  len;
  logic [2:0]  sl_nxt;
  logic [8:0]  lim;

  assign cnt_in = (level_cnt_i > 5'(MAX_LEVELS)) ?
                  5'(MAX_LEVELS) : level_cnt_i;
  assign sl_init = (total_i > 5'd10 && t1s_i < 2'd3) ? 3'd1 : 3'd0;
  assign last = (idx == cnt - 5'd1);
  assign lv = list[idx[3:0]];

  // levelCode and magnitude of the current entry
  always_comb begin
    lvx = {{(11-COEFF_W){lv[COEFF_W-1]}}, lv};
    neg = -lvx;
    mag = lvx[10] ? neg[8:0] : lvx[8:0];
    if (lvx > 11'sd0) lcs = (lvx <<< 1) - 11'sd2;
    else              lcs = -(lvx <<< 1) - 11'sd1;
    if (idx == 5'd0 && t1s != 2'd3) lcs = lcs - 11'sd2;
    lc = lcs[10] ? 9'd0 : lcs[8:0];
  end

  always_comb begin
    thr  = 10'd15 << sl;
    diff = {1'b0, lc} - thr;
    shr  = lc >> sl;
    pre  = 4'd0;
    slen = 4'd0;
    suf  = 12'd0;
    if (sl == 3'd0) begin
      if (lc < 9'd14) begin
        pre = lc[3:0];
      end else if (lc < 9'd30) begin
        pre  = 4'd14;
        slen = 4'd4;
        suf  = 12'(lc - 9'd14);
      end else begin
        pre  = 4'd15;
        slen = 4'd12;
        suf  = 12'(lc - 9'd30);
      end
    end else if ({1'b0, lc} < thr) begin
      pre  = shr[3:0];
      slen = {1'b0, sl};
      suf  = 12'(lc & ((9'd1 << sl) - 9'd1));
    end else begin
      pre  = 4'd15;
      slen = 4'd12;
      suf  = 12'(diff);
    end
    bits = (CODE_W'(1) << slen) | CODE_W'(suf);
    len  = 5'(pre) + 5'd1 + 5'(slen);
  end

  // suffixLength after the current code is accepted
  always_comb begin
    sl_nxt = (sl == 3'd0) ? 3'd1 : sl;
    lim    = 9'd3 << (sl_nxt - 3'd1);
    if (mag > lim && sl_nxt < 3'd6) sl_nxt = sl_nxt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || h264_reset) state <= IDLE;
    else                   state <= nxt;
  end

  always_comb begin
    nxt          = state;
    code_valid_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) nxt = (cnt_in == 5'd0) ? DONE : CALC;
      end
      CALC: nxt = EMIT;
      EMIT: begin
        code_valid_o = 1'b1;
        if (code_ready_i) nxt = last ? DONE : CALC;
      end
      DONE: begin
        done_o = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || h264_reset) begin
      for (int i = 0; i < MAX_LEVELS; i++) list[i] <= '0;
      cnt         <= '0;
      idx         <= '0;
      t1s         <= '0;
      sl          <= '0;
      code_bits_o <= '0;
      code_len_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < MAX_LEVELS; i++) list[i] <= level_list_i[i];
            cnt <= cnt_in;
            t1s <= t1s_i;
            idx <= '0;
            sl  <= sl_init;
          end
        end
        CALC: begin
          code_bits_o <= bits;
          code_len_o  <= len;
        end
        EMIT: begin
          if (code_ready_i) begin
            sl  <= sl_nxt;
            idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_level_encoder.sv
// Directed bench for cavlc_level_encoder with hand-computed codewords.
module tb_cavlc_level_encoder;

  logic clk = 1'b0;
  logic rst;
  logic h264_reset;
  logic start_i;
  logic signed [7:0] lst [16];
  logic [4:0]  level_cnt_i;
  logic [1:0]  t1s_i;
  logic [4:0]  total_i;
  logic        code_ready_i;
  logic        code_valid_o;
  logic [27:0] code_bits_o;
  logic [4:0]  code_len_o;
  logic        busy_o;
  logic        done_o;

  int tests = 0;
  int fails = 0;
  int last_wait;
  logic seen;

  cavlc_level_encoder dut (
    .clk(clk),
    .rst(rst),
    .h264_reset(h264_reset),
    .start_i(start_i),
    .level_list_i(lst),
    .level_cnt_i(level_cnt_i),
    .t1s_i(t1s_i),
    .total_i(total_i),
    .code_ready_i(code_ready_i),
    .code_valid_o(code_valid_o),
    .code_bits_o(code_bits_o),
    .code_len_o(code_len_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_list();
    for (int i = 0; i < 16; i++) lst[i] = 8'sd0;
  endtask

  task automatic start_blk(input int t1s, input int total, input int cnt);
    @(posedge clk) #1;
    t1s_i       = 2'(t1s);
    total_i     = 5'(total);
    level_cnt_i = 5'(cnt);
    start_i     = 1'b1;
    @(posedge clk) #1;
    start_i     = 1'b0;
    level_cnt_i = 5'd0;
    clr_list();
  endtask

  task automatic expect_code(input string tag, input int b, input int l,
                             input int stall);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!code_valid_o && n < 10);
    last_wait = n;
    chk({tag, " valid"}, 32'(code_valid_o), 1);
    chk({tag, " bits"}, 32'(code_bits_o), b);
    chk({tag, " len"}, 32'(code_len_o), l);
    for (int i = 0; i < stall; i++) begin
      start_i = (i == 0);
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(code_valid_o), 1);
      chk({tag, " hold bits"}, 32'(code_bits_o), b);
      chk({tag, " hold len"}, 32'(code_len_o), l);
    end
    start_i      = 1'b0;
    code_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, " gap"}, 32'(code_valid_o), 0);
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, " done"}, 32'(done_o), 1);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done_o), 0);
    chk({tag, " idle"}, 32'(busy_o), 0);
  endtask

  initial begin
    rst          = 1'b1;
    h264_reset   = 1'b0;
    start_i      = 1'b0;
    level_cnt_i  = 5'd0;
    t1s_i        = 2'd0;
    total_i      = 5'd0;
    code_ready_i = 1'b1;
    clr_list();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst valid", 32'(code_valid_o), 0);
    chk("rst bits", 32'(code_bits_o), 0);
    chk("rst len", 32'(code_len_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst done", 32'(done_o), 0);
    rst = 1'b0;

    // T1: single +1 with three trailing ones
    lst[0] = 8'sd1;
    start_blk(3, 4, 1);
    expect_code("t1", 1, 1, 0);
    chk("t1 latency", 32'(last_wait), 2);
    finish_chk("t1");

    // T2: +3, -2
    lst[0] = 8'sd3;
    lst[1] = -8'sd2;
    start_blk(1, 3, 2);
    expect_code("t2a", 1, 3, 0);
    expect_code("t2b", 3, 3, 0);
    finish_chk("t2");

    // T3: 4-bit suffix at prefix 14, then sL=2
    lst[0] = 8'sd8;
    lst[1] = 8'sd1;
    start_blk(3, 5, 2);
    expect_code("t3a", 16, 19, 0);
    expect_code("t3b", 4, 3, 0);
    finish_chk("t3");

    // T4: escape with initial sL=1
    lst[0] = 8'sd100;
    for (int i = 1; i < 11; i++) lst[i] = 8'sd1;
    start_blk(0, 11, 11);
    expect_code("t4a", 4262, 28, 0);
    for (int i = 1; i < 11; i++)
      expect_code($sformatf("t4_%0d", i), 4, 3, 0);
    finish_chk("t4");

    // -128 escapes at sL=0
    lst[0] = -8'sd128;
    start_blk(3, 1, 1);
    expect_code("m128", 4321, 28, 0);
    finish_chk("m128");

    // count above 16 is clamped
    for (int i = 0; i < 16; i++) lst[i] = 8'sd1;
    start_blk(3, 16, 20);
    expect_code("clamp0", 1, 1, 0);
    for (int i = 1; i < 16; i++)
      expect_code($sformatf("clamp%0d", i), 2, 2, 0);
    finish_chk("clamp");

    // T5: stall 5 cycles; start while busy is dropped
    lst[0] = -8'sd3;
    lst[1] = 8'sd5;
    code_ready_i = 1'b0;
    start_blk(0, 2, 2);
    expect_code("t5a", 1, 4, 5);
    expect_code("t5b", 2, 6, 0);
    finish_chk("t5");
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy_o || done_o) seen = 1'b1;
    end
    chk("t5 no queued start", 32'(seen), 0);

    // T6: abort during entry 1, then empty block
    lst[0] = 8'sd2;
    lst[1] = 8'sd2;
    lst[2] = 8'sd2;
    start_blk(3, 3, 3);
    expect_code("t6a", 1, 3, 0);
    code_ready_i = 1'b0;
    @(negedge clk);
    chk("t6 emit1 valid", 32'(code_valid_o), 1);
    h264_reset = 1'b1;
    @(negedge clk);
    chk("t6 abort valid", 32'(code_valid_o), 0);
    chk("t6 abort busy", 32'(busy_o), 0);
    h264_reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk("t6 no done", 32'(seen), 0);
    code_ready_i = 1'b1;
    start_blk(3, 0, 0);
    @(negedge clk);
    chk("t6 empty done", 32'(done_o), 1);
    chk("t6 empty valid", 32'(code_valid_o), 0);
    @(negedge clk);
    chk("t6 empty idle", 32'(busy_o), 0);
    chk("t6 empty pulse", 32'(done_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
